regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths, stamp type and age compare for the write-back arbiter
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STAMP_W    = 3;

    typedef logic [STAMP_W-1:0] stamp_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

    // At most four entries are ever in flight, so a forward distance of 1..4 means a was stamped first.
    function automatic logic stamp_older(input stamp_t a, input stamp_t b);
        stamp_t diff;
        diff = b - a;
        return (diff >= 3'd1) && (diff <= 3'd4);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-requester write queue holding addr, data and acceptance stamp
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  stamp_t                push_stamp,
    input  logic                  pop,
    output logic                  ready,
    output logic                  empty,
    output logic [ADDR_W-1:0]     head_addr,
    output logic [DATA_W-1:0]     head_data,
    output stamp_t                head_stamp,
    output logic [2**ADDR_W-1:0]  pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    stamp_t            r_stamp [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;

    logic [PTR_W-1:0]  w_wr_next;
    logic [PTR_W-1:0]  w_rd_next;

    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;

    assign ready      = ~&r_vld;
    assign empty      = ~|r_vld;
    assign head_addr  = r_addr[r_rd_ptr];
    assign head_data  = r_data[r_rd_ptr];
    assign head_stamp = r_stamp[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= w_wr_next;
            end
            if (pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= w_rd_next;
            end
        end
    end

    // Payload needs no reset: only slots flagged in r_vld are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_addr[r_wr_ptr]  <= push_addr;
            r_data[r_wr_ptr]  <= push_data;
            r_stamp[r_wr_ptr] <= push_stamp;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] != '0)) begin
                pending[r_addr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file write-back arbiter retiring in acceptance order
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_W-1:0]     alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  RegWrite,
    output logic [ADDR_W-1:0]     writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic [2**ADDR_W-1:0]  pending
);

    stamp_t                r_stamp;
    logic                  r_reg_write;
    logic [ADDR_W-1:0]     r_write_reg;
    logic [DATA_W-1:0]     r_write_data;

    logic                  w_alu_push;
    logic                  w_mem_push;
    stamp_t                w_mem_stamp;
    grant_e                w_grant;
    logic                  w_alu_empty;
    logic                  w_mem_empty;
    logic [ADDR_W-1:0]     w_alu_head_addr;
    logic [ADDR_W-1:0]     w_mem_head_addr;
    logic [DATA_W-1:0]     w_alu_head_data;
    logic [DATA_W-1:0]     w_mem_head_data;
    stamp_t                w_alu_head_stamp;
    stamp_t                w_mem_head_stamp;
    logic [2**ADDR_W-1:0]  w_alu_pending;
    logic [2**ADDR_W-1:0]  w_mem_pending;

    assign w_alu_push  = alu_valid && alu_ready && !flush;
    assign w_mem_push  = mem_valid && mem_ready && !flush;
    // ALU takes the lower stamp when both land on the same edge.
    assign w_mem_stamp = r_stamp + stamp_t'(w_alu_push);

    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (w_alu_push),
        .push_addr  (alu_addr),
        .push_data  (alu_data),
        .push_stamp (r_stamp),
        .pop        (w_grant == GNT_ALU),
        .ready      (alu_ready),
        .empty      (w_alu_empty),
        .head_addr  (w_alu_head_addr),
        .head_data  (w_alu_head_data),
        .head_stamp (w_alu_head_stamp),
        .pending    (w_alu_pending)
    );

    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (w_mem_push),
        .push_addr  (mem_addr),
        .push_data  (mem_data),
        .push_stamp (w_mem_stamp),
        .pop        (w_grant == GNT_MEM),
        .ready      (mem_ready),
        .empty      (w_mem_empty),
        .head_addr  (w_mem_head_addr),
        .head_data  (w_mem_head_data),
        .head_stamp (w_mem_head_stamp),
        .pending    (w_mem_pending)
    );

    always_comb begin
        w_grant = GNT_NONE;
        if (!w_alu_empty && (w_mem_empty || stamp_older(w_alu_head_stamp, w_mem_head_stamp))) begin
            w_grant = GNT_ALU;
        end else if (!w_mem_empty) begin
            w_grant = GNT_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stamp <= '0;
        end else if (flush) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + stamp_t'(w_alu_push) + stamp_t'(w_mem_push);
        end
    end

    // Register 0 is hardwired, so its slot pops without a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (flush) begin
            r_reg_write  <= 1'b0;
        end else begin
            case (w_grant)
                GNT_ALU: begin
                    r_reg_write  <= (w_alu_head_addr != '0);
                    r_write_reg  <= w_alu_head_addr;
                    r_write_data <= w_alu_head_data;
                end
                GNT_MEM: begin
                    r_reg_write  <= (w_mem_head_addr != '0);
                    r_write_reg  <= w_mem_head_addr;
                    r_write_data <= w_mem_head_data;
                end
                default: begin
                    r_reg_write  <= 1'b0;
                end
            endcase
        end
    end

    assign RegWrite  = r_reg_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign pending   = w_alu_pending | w_mem_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] pending;

    logic [31:0] rf [32];
    int n_cmp;
    int n_err;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .RegWrite  (RegWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWrite) rf[writeReg] <= writeData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bit_of(input int a);
        return 32'd1 << a;
    endfunction

    task automatic fill_three(input string pfx);
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hC10;
        mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 32'hC20;
        tick();
        check({pfx, "_a_pend"}, pending, bit_of(10) | bit_of(20));
        check({pfx, "_a_mrdy"}, mem_ready, 1);
        alu_addr = 5'd11; alu_data = 32'hC11;
        mem_addr = 5'd21; mem_data = 32'hC21;
        tick();
        check({pfx, "_b_wr"}, RegWrite, 1);
        check({pfx, "_b_reg"}, writeReg, 10);
        check({pfx, "_b_mrdy"}, mem_ready, 0);
        check({pfx, "_b_ardy"}, alu_ready, 1);
        check({pfx, "_b_pend"}, pending, bit_of(11) | bit_of(20) | bit_of(21));
        alu_addr = 5'd12; alu_data = 32'hC12;
        mem_addr = 5'd22; mem_data = 32'hC22;
        tick();
        check({pfx, "_c_reg"}, writeReg, 20);
        check({pfx, "_c_ardy"}, alu_ready, 0);
        check({pfx, "_c_mrdy"}, mem_ready, 1);
        check({pfx, "_c_pend"}, pending, bit_of(11) | bit_of(12) | bit_of(21));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        repeat (2) tick();
        check("rst_wr", RegWrite, 0);
        check("rst_reg", writeReg, 0);
        check("rst_data", writeData, 0);
        check("rst_pend", pending, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ardy", alu_ready, 1);
        check("rst_mrdy", mem_ready, 1);

        // single ALU write, two-edge latency
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        check("t1_wr_early", RegWrite, 0);
        check("t1_pend", pending, bit_of(5));
        tick();
        check("t1_wr", RegWrite, 1);
        check("t1_reg", writeReg, 5);
        check("t1_data", writeData, 32'h0000_1234);
        check("t1_pend_clr", pending, 0);
        tick();
        check("t1_wr_off", RegWrite, 0);
        check("t1_hold", writeData, 32'h0000_1234);
        check("t1_rf", rf[5], 32'h0000_1234);

        // same-edge collision on r7
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hAAAA_AAAA;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h5555_5555;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("t2_pend", pending, bit_of(7));
        tick();
        check("t2_first_wr", RegWrite, 1);
        check("t2_first", writeData, 32'hAAAA_AAAA);
        tick();
        check("t2_second_wr", RegWrite, 1);
        check("t2_second", writeData, 32'h5555_5555);
        tick();
        check("t2_idle", RegWrite, 0);
        check("t2_rf", rf[7], 32'h5555_5555);

        // load stream r1..r6
        mem_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            mem_addr = 5'(i); mem_data = 32'(32'h100 + i);
            tick();
            check("t3_mrdy", mem_ready, 1);
            if (i > 1) begin
                check("t3_wr", RegWrite, 1);
                check("t3_reg", writeReg, 64'(i - 1));
                check("t3_data", writeData, 64'(32'h100 + i - 1));
            end
        end
        mem_valid = 1'b0;
        tick();
        check("t3_last_wr", RegWrite, 1);
        check("t3_last_reg", writeReg, 6);
        tick();
        check("t3_idle", RegWrite, 0);
        check("t3_rf", rf[6], 32'h106);

        // r0 write is popped silently, then r3 follows in order
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        check("t4_pend0", pending, 0);
        alu_addr = 5'd3; alu_data = 32'h33;
        tick();
        alu_valid = 1'b0;
        check("t4_r0_nowr", RegWrite, 0);
        check("t4_pend3", pending, bit_of(3));
        tick();
        check("t4_r3_wr", RegWrite, 1);
        check("t4_r3_reg", writeReg, 3);
        check("t4_r3_data", writeData, 32'h33);
        tick();
        check("t4_idle", RegWrite, 0);

        // dual accepts every other edge; stamp counter starts at 3 and wraps on pair 2
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(16 + i); alu_data = 32'(32'hA000 + i);
            mem_valid = 1'b1; mem_addr = 5'(24 + i); mem_data = 32'(32'hB000 + i);
            tick();
            alu_valid = 1'b0; mem_valid = 1'b0;
            if (i > 0) begin
                check("t6_mem_wr", RegWrite, 1);
                check("t6_mem_reg", writeReg, 64'(24 + i - 1));
            end
            tick();
            check("t6_alu_reg", writeReg, 64'(16 + i));
            check("t6_alu_data", writeData, 64'(32'hA000 + i));
        end
        tick();
        check("t6_tail_reg", writeReg, 28);
        check("t6_tail_data", writeData, 32'hB004);
        tick();
        check("t6_idle", RegWrite, 0);
        check("t6_pend", pending, 0);

        // flush with a same-edge ALU request
        fill_three("t5f");
        flush = 1'b1; alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hC13; mem_valid = 1'b0;
        tick();
        flush = 1'b0; alu_valid = 1'b0;
        check("t5f_wr", RegWrite, 0);
        check("t5f_pend", pending, 0);
        check("t5f_ardy", alu_ready, 1);
        check("t5f_mrdy", mem_ready, 1);
        check("t5f_hold", writeReg, 20);
        tick();
        check("t5f_wr2", RegWrite, 0);
        check("t5f_pend2", pending, 0);
        tick();
        check("t5f_wr3", RegWrite, 0);

        // same scenario with an asynchronous reset pulse
        fill_three("t5r");
        alu_valid = 1'b1; alu_addr = 5'd13; mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5r_async_wr", RegWrite, 0);
        check("t5r_async_pend", pending, 0);
        check("t5r_async_reg", writeReg, 0);
        tick();
        rst_n = 1'b1; alu_valid = 1'b0;
        check("t5r_ardy", alu_ready, 1);
        check("t5r_mrdy", mem_ready, 1);
        tick();
        check("t5r_wr", RegWrite, 0);
        check("t5r_pend", pending, 0);
        tick();
        check("t5r_wr2", RegWrite, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
